// File: rtl/slot_payout_ctrl_pkg.sv
// rtl/slot_payout_ctrl_pkg.sv - shared symbols, payout amounts, win codes and FSM states
package slot_payout_ctrl_pkg;

  localparam logic [2:0] SYM_SEVEN = 3'b111;

  localparam int PAY_W = 13;
  localparam logic [PAY_W-1:0] PAY_JACKPOT = 13'd5000;
  localparam logic [PAY_W-1:0] PAY_TRIPLE  = 13'd500;
  localparam logic [PAY_W-1:0] PAY_PAIR    = 13'd50;

  typedef enum logic [1:0] {
    WIN_NONE    = 2'd0,
    WIN_PAIR    = 2'd1,
    WIN_TRIPLE  = 2'd2,
    WIN_JACKPOT = 2'd3
  } win_class_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPIN   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_PAY    = 3'd4
  } state_e;

endpackage

// File: rtl/slot_win_eval.sv
// rtl/slot_win_eval.sv - combinational reel classifier, shared with the display logic
module slot_win_eval
  import slot_payout_ctrl_pkg::*;
(
  input  logic [8:0]       reels,
  output logic [1:0]       win_class,
  output logic [PAY_W-1:0] payout
);

  logic [2:0] r1, r2, r3;

  assign r1 = reels[8:6];
  assign r2 = reels[5:3];
  assign r3 = reels[2:0];

  always_comb begin
    win_class = WIN_NONE;
    payout    = '0;
    if (r1 == r2 && r2 == r3) begin
      if (r1 == SYM_SEVEN) begin
        win_class = WIN_JACKPOT;
        payout    = PAY_JACKPOT;
      end else begin
        win_class = WIN_TRIPLE;
        payout    = PAY_TRIPLE;
      end
    end else if (r1 == r2 || r2 == r3 || r1 == r3) begin
      win_class = WIN_PAIR;
      payout    = PAY_PAIR;
    end
  end

endmodule

// File: rtl/slot_payout_ctrl.sv
// rtl/slot_payout_ctrl.sv - spin sequencing, reel sampling and saturating credit payout
module slot_payout_ctrl
  import slot_payout_ctrl_pkg::*;
#(
  parameter int CRED_W        = 16,
  parameter int BET           = 10,
  parameter int COIN_VALUE    = 100,
  parameter int SPIN_CYCLES   = 50,
  parameter int SETTLE_CYCLES = 2,
  parameter int PAY_STEP      = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_in,
  input  logic              spin_req,
  input  logic [2:0]        rng1,
  input  logic [2:0]        rng2,
  input  logic [2:0]        rng3,
  output logic              button_press,
  output logic [CRED_W-1:0] credits,
  output logic [8:0]        reels_q,
  output logic [1:0]        win_class,
  output logic              busy,
  output logic              spin_reject,
  output logic              spin_done
);

  localparam int CNT_W = $clog2(SPIN_CYCLES + SETTLE_CYCLES + 1);
  localparam int SUM_W = CRED_W + 2;
  localparam logic [SUM_W-1:0] CRED_MAX = {2'b00, {CRED_W{1'b1}}};

  state_e            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [PAY_W-1:0]  pay_rem, pay_rem_d, pay_tick;
  logic [8:0]        reels_d;
  logic [1:0]        win_d, eval_class;
  logic [PAY_W-1:0]  eval_pay;
  logic              coin_q, spin_q, coin_ev, spin_ev;
  logic              debit, done_d, reject_d;
  logic [SUM_W-1:0]  sum;
  logic [CRED_W-1:0] credits_d;

  assign coin_ev      = coin_in && !coin_q;
  assign spin_ev      = spin_req && !spin_q;
  assign busy         = (state != ST_IDLE);
  assign button_press = (state == ST_SPIN);

  slot_win_eval u_win_eval (
    .reels     (reels_q),
    .win_class (eval_class),
    .payout    (eval_pay)
  );

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pay_rem_d = pay_rem;
    reels_d   = reels_q;
    win_d     = win_class;
    pay_tick  = '0;
    debit     = 1'b0;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spin_ev) begin
          if (credits >= CRED_W'(BET)) begin
            debit   = 1'b1;
            cnt_d   = CNT_W'(SPIN_CYCLES - 1);
            state_d = ST_SPIN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_SPIN: begin
        if (cnt == '0) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          reels_d = {rng1, rng2, rng3};
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_EVAL: begin
        win_d     = eval_class;
        pay_rem_d = eval_pay;
        state_d   = ST_PAY;
      end
      ST_PAY: begin
        // A losing spin still spends one PAY cycle so spin_done always fires.
        pay_tick  = (pay_rem > PAY_W'(PAY_STEP)) ? PAY_W'(PAY_STEP) : pay_rem;
        pay_rem_d = pay_rem - pay_tick;
        if (pay_rem_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Debit, coin and payout tick merge into a single sum so only one saturation applies.
  always_comb begin
    sum = SUM_W'(credits)
        - (debit   ? SUM_W'(BET)        : '0)
        + (coin_ev ? SUM_W'(COIN_VALUE) : '0)
        + SUM_W'(pay_tick);
    credits_d = (sum > CRED_MAX) ? {CRED_W{1'b1}} : sum[CRED_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pay_rem     <= '0;
      reels_q     <= '0;
      win_class   <= '0;
      credits     <= '0;
      coin_q      <= 1'b0;
      spin_q      <= 1'b0;
      spin_done   <= 1'b0;
      spin_reject <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pay_rem     <= pay_rem_d;
      reels_q     <= reels_d;
      win_class   <= win_d;
      credits     <= credits_d;
      coin_q      <= coin_in;
      spin_q      <= spin_req;
      spin_done   <= done_d;
      spin_reject <= reject_d;
    end
  end

endmodule

// File: tb/tb_slot_payout_ctrl.sv
// tb/tb_slot_payout_ctrl.sv - scoreboard bench for slot_payout_ctrl
module tb_slot_payout_ctrl;

  localparam int BET = 10, COIN = 100, SPINC = 50, SETTLE = 2, STEP = 50, CMAX = 65535;

  logic        clk = 1'b0, reset = 1'b1, coin_in = 1'b0, spin_req = 1'b0;
  logic [2:0]  rng1 = '0, rng2 = '0, rng3 = '0;
  logic        button_press, busy, spin_reject, spin_done;
  logic [15:0] credits;
  logic [8:0]  reels_q;
  logic [1:0]  win_class;

  slot_payout_ctrl dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .spin_req(spin_req),
    .rng1(rng1), .rng2(rng2), .rng3(rng3),
    .button_press(button_press), .credits(credits), .reels_q(reels_q),
    .win_class(win_class), .busy(busy), .spin_reject(spin_reject), .spin_done(spin_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    int         cred;
    int         wcls;
    int         busy_cycles;
    logic [8:0] reels;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  int model_cred = 0;
  int busy_cnt = 0, bp_cnt = 0, cred_prev = 0;
  bit busy_prev = 0, bp_prev = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pay_of(input int a, input int b, input int c);
    if (a == b && b == c) return (a == 7) ? 5000 : 500;
    if (a == b || b == c || a == c) return 50;
    return 0;
  endfunction

  function automatic int class_of(input int a, input int b, input int c);
    if (a == b && b == c) return (a == 7) ? 3 : 2;
    if (a == b || b == c || a == c) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a spin outcome.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0; busy_prev = 0; bp_cnt = 0; bp_prev = 0; cred_prev = 0;
    end else begin
      if (busy && !busy_prev) busy_cnt = 1;
      else if (busy) busy_cnt++;
      if (button_press) bp_cnt++;
      else if (bp_prev) begin
        check("button_press_width", bp_cnt, SPINC);
        bp_cnt = 0;
      end
      if (int'(credits) < cred_prev) check("credit_drop", cred_prev - int'(credits), BET);
      if (spin_done || spin_reject) begin
        if (sb.size() == 0) check("unexpected_event", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("event_kind", int'(spin_done), int'(mon_e.is_done));
          check("credits", int'(credits), mon_e.cred);
          if (mon_e.is_done) begin
            check("win_class", int'(win_class), mon_e.wcls);
            check("reels_q", int'(reels_q), int'(mon_e.reels));
            check("busy_cycles", busy_cnt, mon_e.busy_cycles);
          end else begin
            check("reject_busy", int'(busy), 0);
            check("reject_button", int'(button_press), 0);
          end
        end
      end
      busy_prev = busy;
      bp_prev   = button_press;
      cred_prev = int'(credits);
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic coin();
    @(negedge clk) coin_in = 1'b1;
    model_cred = sat(model_cred + COIN);
    @(negedge clk) coin_in = 1'b0;
  endtask

  task automatic spin(input int a, input int b, input int c, input int coin_delay);
    exp_t e;
    int   p, pre;
    rng1 = 3'(a); rng2 = 3'(b); rng3 = 3'(c);
    pre = model_cred;
    @(negedge clk) spin_req = 1'b1;
    e.reels = {3'(a), 3'(b), 3'(c)};
    if (model_cred >= BET) begin
      p = pay_of(a, b, c);
      model_cred = sat(model_cred - BET + p + ((coin_delay > 0) ? COIN : 0));
      e.is_done = 1'b1;
      e.wcls = class_of(a, b, c);
      e.busy_cycles = SPINC + SETTLE + 1 + ((p == 0) ? 1 : (p + STEP - 1) / STEP);
    end else begin
      e.is_done = 1'b0;
      e.wcls = 0;
      e.busy_cycles = 0;
    end
    e.cred = model_cred;
    sb.push_back(e);
    @(negedge clk) spin_req = 1'b0;
    if (e.is_done) check("debit", int'(credits), pre - BET);
    if (coin_delay > 0) begin
      repeat (coin_delay) @(negedge clk);
      coin_in = 1'b1;
      @(negedge clk) coin_in = 1'b0;
    end
    wait_drain();
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    sb.delete();
    model_cred = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a, b, c, kind, seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_credits", int'(credits), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_button", int'(button_press), 0);
    check("rst_win_class", int'(win_class), 0);
    check("rst_reels", int'(reels_q), 0);
    check("rst_pulses", int'(spin_done) + int'(spin_reject), 0);

    spin(1, 2, 3, 0);            // no credits: reject
    coin();
    spin(7, 7, 7, 0);            // jackpot: 90 then 5090
    coin();
    spin(5, 6, 1, 0);            // no win
    spin(2, 2, 2, 0);            // triple
    spin(3, 4, 3, 0);            // pair

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(1, 0) == 1) coin();
      kind = $urandom_range(2, 0);
      a = $urandom_range(7, 0);
      b = (kind == 2) ? $urandom_range(7, 0) : a;
      c = (kind == 0) ? a : $urandom_range(7, 0);
      spin(a, b, c, 0);
    end

    do_reset();
    repeat (655) coin();
    spin(7, 7, 7, 70);           // saturate at 65535 with a coin landing during PAY

    do_reset();
    coin();
    rng1 = 3'd1; rng2 = 3'd1; rng3 = 3'd1;
    @(negedge clk) spin_req = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_button", int'(button_press), 0);
    check("mid_rst_credits", int'(credits), 0);
    check("mid_rst_busy", int'(busy), 0);
    sb.delete();
    model_cred = 0;
    begin
      exp_t r;
      r.is_done = 1'b0; r.cred = 0; r.wcls = 0; r.busy_cycles = 0; r.reels = '0;
      sb.push_back(r);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_drain();
    coin();
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || button_press) seen = 1;
    end
    check("held_spin_ignored", seen, 0);
    check("held_spin_credits", int'(credits), model_cred);
    spin_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
